// File: rtl/button_bounce_gen_pkg.sv
// Shared debounce defines: state types, widths and the LFSR step function.
package button_bounce_gen_pkg;

    localparam int unsigned LFSR_W = 16;
    localparam int unsigned WIN_W  = 16;

    // Debounce filter state type, shared with the debouncer side of the codebase.
    typedef enum logic [1:0] {
        ST_DB_IDLE   = 2'd0,
        ST_DB_WAIT   = 2'd1,
        ST_DB_STABLE = 2'd2
    } estado_db_t;

    // Bounce generator state type.
    typedef enum logic [1:0] {
        ST_BG_LOW          = 2'd0,
        ST_BG_BOUNCE_RISE  = 2'd1,
        ST_BG_HIGH         = 2'd2,
        ST_BG_BOUNCE_FALL  = 2'd3
    } estado_bg_t;

    // One step of the 16-bit Fibonacci LFSR, taps 16/14/13/11 (maximal length).
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    endfunction

endpackage

// File: rtl/button_bounce_gen_lfsr.sv
// Free-running 16-bit pseudo-random source for bounce glitch lengths.
module bg_lfsr16
    import button_bounce_gen_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic [LFSR_W-1:0] lfsr_o
);

    // A zero seed would lock the register at zero, so fall back to 1.
    localparam logic [LFSR_W-1:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

    // Advance every cycle regardless of the consumer's state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lfsr_o <= SEED_NZ;
        end else begin
            lfsr_o <= lfsr_next(lfsr_o);
        end
    end

endmodule

// File: rtl/button_bounce_gen.sv
// Mechanical push-button emulator: turns a clean press level into a line that
// bounces pseudo-randomly for a fixed window before settling.
module button_bounce_gen
    import button_bounce_gen_pkg::*;
#(
    parameter int unsigned BOUNCE_CYCLES = 1000,
    parameter int unsigned GLITCH_W      = 4,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       press_i,
    output logic       signal_o,
    output logic       settled_o,
    output estado_bg_t state_o
);

    localparam int unsigned     HOLD_W   = GLITCH_W + 1;
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(BOUNCE_CYCLES - 1);

    logic [LFSR_W-1:0] lfsr;
    logic [WIN_W-1:0]  win_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_seed;
    logic              unused_lfsr_bits;

    bg_lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .lfsr_o (lfsr)
    );

    // Random hold length: low GLITCH_W bits of the LFSR, zero-extended.
    assign hold_seed        = HOLD_W'(lfsr[GLITCH_W-1:0]);
    assign unused_lfsr_bits = ^lfsr[LFSR_W-1:GLITCH_W];

    // Bounce FSM with window/hold counters and registered line outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_o   <= ST_BG_LOW;
            signal_o  <= 1'b0;
            settled_o <= 1'b1;
            win_cnt   <= '0;
            hold_cnt  <= '0;
        end else begin
            case (state_o)
                ST_BG_LOW: begin
                    if (press_i) begin
                        state_o   <= ST_BG_BOUNCE_RISE;
                        signal_o  <= 1'b1;
                        settled_o <= 1'b0;
                        win_cnt   <= WIN_LOAD;
                        hold_cnt  <= hold_seed;
                    end
                end
                ST_BG_HIGH: begin
                    if (!press_i) begin
                        state_o   <= ST_BG_BOUNCE_FALL;
                        signal_o  <= 1'b0;
                        settled_o <= 1'b0;
                        win_cnt   <= WIN_LOAD;
                        hold_cnt  <= hold_seed;
                    end
                end
                ST_BG_BOUNCE_RISE, ST_BG_BOUNCE_FALL: begin
                    if (win_cnt == '0) begin
                        // Window expiry wins over any pending toggle.
                        signal_o  <= (state_o == ST_BG_BOUNCE_RISE);
                        settled_o <= 1'b1;
                        state_o   <= (state_o == ST_BG_BOUNCE_RISE) ? ST_BG_HIGH : ST_BG_LOW;
                    end else begin
                        win_cnt <= win_cnt - WIN_W'(1);
                        if (hold_cnt == '0) begin
                            signal_o <= ~signal_o;
                            hold_cnt <= hold_seed;
                        end else begin
                            hold_cnt <= hold_cnt - HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    state_o   <= ST_BG_LOW;
                    signal_o  <= 1'b0;
                    settled_o <= 1'b1;
                end
            endcase
        end
    end

endmodule
